// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART sender through a txen/txstatus
// handshake. One byte is popped into txdata and held for the whole frame;
// the next byte is only launched once the sender has gone busy and then
// returned to idle.
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          ovf_clr,
  input  logic          txstatus,
  output logic [7:0]    txdata,
  output logic          txen,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state_q;
  logic [7:0]      txdata_q;
  logic            txen_q;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [DEPTH];

  logic            pop;
  logic            push;
  logic            drop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign busy     = (state_q != IDLE);
  assign count    = count_q;
  assign overflow = ovf_q;
  assign txdata   = txdata_q;
  assign txen     = txen_q;

  // A pop frees a slot in the same cycle, so a push into a full queue is
  // still accepted when the FSM is popping at that edge.
  always_comb begin
    pop  = (state_q == IDLE) && !empty && txstatus;
    push = wr_en && (!full || pop);
    drop = wr_en && !push;

    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Queue bookkeeping registers: pointers, occupancy and sticky overflow.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // Sender handshake FSM with registered txdata and one-cycle txen pulse.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      txen_q   <= 1'b0;
      txdata_q <= 8'h00;
    end else begin
      txen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            txdata_q <= mem_q[rptr_q];
            txen_q   <= 1'b1;
            state_q  <= LAUNCH;
          end
        end
        LAUNCH:    state_q <= WAIT_BUSY;
        WAIT_BUSY: if (!txstatus) state_q <= WAIT_DONE;
        WAIT_DONE: if (txstatus)  state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        ovf_clr = 1'b0;
  logic        txstatus = 1'b1;
  logic [7:0]  txdata;
  logic        txen;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
  logic        busy;

  uart_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .txstatus(txstatus), .txdata(txdata), .txen(txen),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int npass  = 0;
  int ntotal = 0;

  // Reference model: a byte queue, the byte handed to the sender, a sticky
  // overflow bit and the handshake phase (0 idle, 1 launch pulse,
  // 2 waiting for sender to go busy, 3 waiting for sender to finish).
  logic [7:0] mq[$];
  logic [7:0] m_txd;
  logic       m_ovf;
  int         m_phase;
  bit         mchk;

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_txd   = 8'h00;
    m_ovf   = 1'b0;
    m_phase = 0;
  endtask

  task automatic model_step();
    bit pop, acc;
    pop = (m_phase == 0) && (mq.size() != 0) && (txstatus == 1'b1);
    acc = (wr_en == 1'b1) && ((mq.size() < DEPTH) || pop);
    if (pop) m_txd = mq.pop_front();
    if (acc) mq.push_back(wr_data);
    if (wr_en && !acc) m_ovf = 1'b1;
    else if (ovf_clr)  m_ovf = 1'b0;
    case (m_phase)
      0: if (pop) m_phase = 1;
      1: m_phase = 2;
      2: if (!txstatus) m_phase = 3;
      3: if (txstatus) m_phase = 0;
      default: m_phase = 0;
    endcase
  endtask

  task automatic chk_model();
    chk("m_txen",     int'(txen),     int'(m_phase == 1));
    chk("m_txdata",   int'(txdata),   int'(m_txd));
    chk("m_count",    int'(count),    mq.size());
    chk("m_full",     int'(full),     int'(mq.size() == DEPTH));
    chk("m_empty",    int'(empty),    int'(mq.size() == 0));
    chk("m_overflow", int'(overflow), int'(m_ovf));
    chk("m_busy",     int'(busy),     int'(m_phase != 0));
  endtask

  // One clock: model consumes the inputs the DUT samples, outputs are
  // compared on the falling edge.
  task automatic cyc();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    if (mchk) chk_model();
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_txen"},     int'(txen),     0);
    chk({tag, "_txdata"},   int'(txdata),   0);
    chk({tag, "_count"},    int'(count),    0);
    chk({tag, "_empty"},    int'(empty),    1);
    chk({tag, "_full"},     int'(full),     0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_busy"},     int'(busy),     0);
  endtask

  // Called at a falling edge; outputs are checked before any rising edge.
  task automatic do_reset(input string tag);
    reset   = 1'b1;
    wr_en   = 1'b0;
    ovf_clr = 1'b0;
    #1;
    model_reset();
    chk_rst_vals(tag);
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
  endtask

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       oc;
    logic       ts;
    logic       e_txen;
    logic [7:0] e_txd;
    int         e_cnt;
    logic       e_busy;
    logic       e_ovf;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx[$];
    int sent, scnt, seen;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3C, 0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 1'b1, 1'b0};

    mchk = 1'b1;
    model_reset();
    @(negedge CLK);
    do_reset("rst0");

    // Directed vector table
    txstatus = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = tbl[i].we; wr_data = tbl[i].wd; ovf_clr = tbl[i].oc; txstatus = tbl[i].ts;
      cyc();
      chk($sformatf("tbl%0d_txen", i),     int'(txen),     int'(tbl[i].e_txen));
      chk($sformatf("tbl%0d_txdata", i),   int'(txdata),   int'(tbl[i].e_txd));
      chk($sformatf("tbl%0d_count", i),    int'(count),    tbl[i].e_cnt);
      chk($sformatf("tbl%0d_busy", i),     int'(busy),     int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_overflow", i), int'(overflow), int'(tbl[i].e_ovf));
    end
    wr_en = 1'b0; ovf_clr = 1'b0;

    // Single byte with a long frame
    do_reset("rst1");
    txstatus = 1'b1;
    wr_en = 1'b1; wr_data = 8'hA5;
    cyc();
    wr_en = 1'b0;
    chk("single_txen_early", int'(txen), 0);
    cyc();
    chk("single_txen", int'(txen), 1);
    chk("single_txdata", int'(txdata), 8'hA5);
    txstatus = 1'b0;
    for (int i = 0; i < 120; i++) cyc();
    chk("single_hold_txdata", int'(txdata), 8'hA5);
    chk("single_busy_mid", int'(busy), 1);
    txstatus = 1'b1;
    cyc();
    chk("single_busy_end", int'(busy), 0);
    chk("single_empty_end", int'(empty), 1);

    // Burst of 20 bytes, wrapping the pointers
    do_reset("rst2");
    txstatus = 1'b1;
    sent = 0; scnt = 0;
    rx.delete();
    for (int n = 0; n < 2000 && rx.size() < 20; n++) begin
      wr_en = (sent < 20) && (n % 4 == 0);
      wr_data = 8'(sent);
      cyc();
      if (wr_en) sent++;
      wr_en = 1'b0;
      if (txen) begin
        rx.push_back(txdata);
        scnt = 6;
      end
      txstatus = (scnt == 0);
      if (scnt > 0) scnt--;
    end
    chk("burst_nbytes", rx.size(), 20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("burst_byte%0d", i), (i < rx.size()) ? int'(rx[i]) : -1, i);
    txstatus = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    // Overflow with the sender stuck busy
    do_reset("rst3");
    txstatus = 1'b0;
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      cyc();
    end
    wr_en = 1'b0;
    chk("ovf_count", int'(count), 16);
    chk("ovf_full", int'(full), 1);
    chk("ovf_flag", int'(overflow), 1);
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);

    // Full queue: push and pop in the same cycle
    wr_en = 1'b1; wr_data = 8'h77; txstatus = 1'b1;
    cyc();
    wr_en = 1'b0;
    chk("fullpp_count", int'(count), 16);
    chk("fullpp_overflow", int'(overflow), 0);
    chk("fullpp_txen", int'(txen), 1);
    chk("fullpp_txdata", int'(txdata), 8'h40);

    // Reset in the middle of a frame
    do_reset("rst4");
    txstatus = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 * (i + 1));
      cyc();
    end
    wr_en = 1'b0; txstatus = 1'b0;
    cyc();
    chk("midrst_busy_before", int'(busy), 1);
    chk("midrst_count_before", int'(count), 3);
    do_reset("midrst");
    txstatus = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (txen) seen++;
    end
    chk("midrst_no_txen", seen, 0);

    // Randomized traffic against the model
    do_reset("rst5");
    for (int i = 0; i < 3000; i++) begin
      wr_en    = ($urandom_range(0, 99) < 55);
      wr_data  = 8'($urandom);
      ovf_clr  = ($urandom_range(0, 99) < 8);
      txstatus = ($urandom_range(0, 99) < 45);
      cyc();
    end
    wr_en = 1'b0; ovf_clr = 1'b0;

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
